// File: rtl/instr_fetch.sv
// Program sequencer: loadable 16-word program store feeding decode over valid/ready.
// Optional INSTR_FETCH_LOOP_EN: PC wraps past the last word instead of halting.
module instr_fetch #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              start,
  input  logic              stop,
  input  logic              instr_ready,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

`ifdef INSTR_FETCH_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] pc_nxt;
  logic [15:0]       cur_word, nxt_word;
  logic              cur_halt, nxt_halt, end_of_mem, load_ok, handshake;

  assign pc_nxt     = pc + ADDR_W'(1);
  assign cur_word   = mem[pc];
  assign nxt_word   = mem[pc_nxt];
  assign cur_halt   = &cur_word[15:12];
  assign nxt_halt   = &nxt_word[15:12];
  assign end_of_mem = (pc == ADDR_W'(DEPTH-1)) && !LOOP_EN;
  assign load_ok    = (state == IDLE) || (state == HALT);
  assign handshake  = instr_valid && instr_ready;

  assign busy   = (state == FETCH) || (state == ISSUE);
  assign halted = (state == HALT);

  // Program store is deliberately outside reset so a reset mid-run keeps the program.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      instruction <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (stop) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end else if (cur_halt) begin
            instr_valid <= 1'b0;
            state       <= HALT;
          end else begin
            instruction <= cur_word;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (stop) begin
            // A coincident handshake is consumed, but pc stays on it.
            instr_valid <= 1'b0;
            state       <= IDLE;
          end else if (handshake) begin
            if (end_of_mem) begin
              instr_valid <= 1'b0;
              state       <= HALT;
            end else begin
              pc <= pc_nxt;
              if (nxt_halt) begin
                instr_valid <= 1'b0;
                state       <= HALT;
              end else begin
                instruction <= nxt_word;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: run, stall, end-of-memory, stop, load lockout, reset.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n, load_en, start, stop, instr_ready;
  logic [3:0]  load_addr, pc;
  logic [15:0] load_data, instruction;
  logic        instr_valid, busy, halted;
  int          nvec = 0, nerr = 0;

  instr_fetch #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stop(stop), .instr_ready(instr_ready),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_prog();
    load_word(4'd0, 16'h0650); load_word(4'd1, 16'h1888);
    load_word(4'd2, 16'h8AC0); load_word(4'd3, 16'h9050);
    load_word(4'd4, 16'hF000);
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; stop = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    nvec++;
    if ({instruction, instr_valid, pc, busy, halted} !== 23'd0) begin
      nerr++; $display("FAIL reset_state got=%h want=%h", {instruction, instr_valid, pc, busy, halted}, 23'd0);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_basic_run();
    logic [15:0] exp_i [4];
    exp_i[0] = 16'h0650; exp_i[1] = 16'h1888; exp_i[2] = 16'h8AC0; exp_i[3] = 16'h9050;
    load_prog();
    instr_ready = 1'b1;
    do_start();
    nvec++;
    if ({busy, instr_valid} !== 2'b10) begin
      nerr++; $display("FAIL basic_fetch_state got=%b want=10", {busy, instr_valid});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if ({instr_valid, pc, instruction} !== {1'b1, 4'(i), exp_i[i]}) begin
        nerr++; $display("FAIL basic_issue%0d got=%h want=%h", i, {instr_valid, pc, instruction}, {1'b1, 4'(i), exp_i[i]});
      end
      tick();
    end
    nvec++;
    if ({halted, busy, instr_valid, pc} !== {3'b100, 4'd4}) begin
      nerr++; $display("FAIL basic_halt got=%h want=%h", {halted, busy, instr_valid, pc}, {3'b100, 4'd4});
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    instr_ready = 1'b1;
    do_start(); tick(); tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if ({instr_valid, pc, instruction} !== {1'b1, 4'd1, 16'h1888}) begin
        nerr++; $display("FAIL stall_hold%0d got=%h want=%h", i, {instr_valid, pc, instruction}, {1'b1, 4'd1, 16'h1888});
      end
    end
    instr_ready = 1'b1; tick();
    nvec++;
    if ({instr_valid, pc, instruction} !== {1'b1, 4'd2, 16'h8AC0}) begin
      nerr++; $display("FAIL stall_release got=%h want=%h", {instr_valid, pc, instruction}, {1'b1, 4'd2, 16'h8AC0});
    end
    tick(); tick();
    nvec++;
    if (halted !== 1'b1) begin
      nerr++; $display("FAIL stall_halt got=%b want=1", halted);
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_end_of_mem();
    for (int a = 0; a < 16; a++) load_word(4'(a), 16'h0650);
    instr_ready = 1'b1;
    do_start(); tick();
    for (int i = 0; i < 15; i++) tick();
    nvec++;
    if ({instr_valid, pc, instruction} !== {1'b1, 4'd15, 16'h0650}) begin
      nerr++; $display("FAIL eom_last got=%h want=%h", {instr_valid, pc, instruction}, {1'b1, 4'd15, 16'h0650});
    end
    tick();
`ifdef INSTR_FETCH_LOOP_EN
    nvec++;
    if ({halted, instr_valid, pc, instruction} !== {2'b01, 4'd0, 16'h0650}) begin
      nerr++; $display("FAIL eom_wrap got=%h want=%h", {halted, instr_valid, pc, instruction}, {2'b01, 4'd0, 16'h0650});
    end
    stop = 1'b1; tick(); stop = 1'b0;
    nvec++;
    if ({busy, instr_valid} !== 2'b00) begin
      nerr++; $display("FAIL eom_wrap_stop got=%b want=00", {busy, instr_valid});
    end
`else
    nvec++;
    if ({halted, instr_valid, pc} !== {2'b10, 4'd15}) begin
      nerr++; $display("FAIL eom_halt got=%h want=%h", {halted, instr_valid, pc}, {2'b10, 4'd15});
    end
`endif
    instr_ready = 1'b0;
  endtask

  task automatic test_stop();
    load_prog();
    instr_ready = 1'b1;
    do_start(); tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    nvec++;
    if ({busy, halted, instr_valid, pc} !== {3'b000, 4'd1}) begin
      nerr++; $display("FAIL stop_idle got=%h want=%h", {busy, halted, instr_valid, pc}, {3'b000, 4'd1});
    end
    tick(); tick();
    nvec++;
    if ({busy, instr_valid} !== 2'b00) begin
      nerr++; $display("FAIL stop_no_issue got=%b want=00", {busy, instr_valid});
    end
    stop = 1'b1; tick(); stop = 1'b0;
    nvec++;
    if ({busy, halted, pc} !== {2'b00, 4'd1}) begin
      nerr++; $display("FAIL stop_in_idle got=%h want=%h", {busy, halted, pc}, {2'b00, 4'd1});
    end
    do_start(); tick();
    nvec++;
    if ({instr_valid, pc, instruction} !== {1'b1, 4'd0, 16'h0650}) begin
      nerr++; $display("FAIL stop_restart got=%h want=%h", {instr_valid, pc, instruction}, {1'b1, 4'd0, 16'h0650});
    end
  endtask

  task automatic test_load_lock_and_reset();
    load_en = 1'b1; load_addr = 4'd2; load_data = 16'hFFFF;
    tick();
    load_en = 1'b0; tick();
    nvec++;
    if ({instr_valid, pc, instruction} !== {1'b1, 4'd2, 16'h8AC0}) begin
      nerr++; $display("FAIL load_locked got=%h want=%h", {instr_valid, pc, instruction}, {1'b1, 4'd2, 16'h8AC0});
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    nvec++;
    if ({instruction, instr_valid, pc, busy, halted} !== 23'd0) begin
      nerr++; $display("FAIL midrun_reset got=%h want=%h", {instruction, instr_valid, pc, busy, halted}, 23'd0);
    end
    do_start(); tick();
    nvec++;
    if ({instr_valid, pc, instruction} !== {1'b1, 4'd0, 16'h0650}) begin
      nerr++; $display("FAIL reset_restart got=%h want=%h", {instr_valid, pc, instruction}, {1'b1, 4'd0, 16'h0650});
    end
    tick(); tick();
    nvec++;
    if ({instr_valid, pc, instruction} !== {1'b1, 4'd2, 16'h8AC0}) begin
      nerr++; $display("FAIL mem_retained got=%h want=%h", {instr_valid, pc, instruction}, {1'b1, 4'd2, 16'h8AC0});
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_load_start_same_cycle();
    stop = 1'b1; tick(); stop = 1'b0;
    instr_ready = 1'b1;
    load_en = 1'b1; load_addr = 4'd0; load_data = 16'hF000; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    nvec++;
    if ({halted, instr_valid, pc} !== {2'b10, 4'd0}) begin
      nerr++; $display("FAIL load_start_halt got=%h want=%h", {halted, instr_valid, pc}, {2'b10, 4'd0});
    end
    instr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_stall();
    test_end_of_mem();
    test_stop();
    test_load_lock_and_reset();
    test_load_start_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
